// File: rtl/traffic_pkg.sv
// Shared definitions for the two-way intersection controller: phase state
// encoding and the lamp pattern shown in each phase.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_A = 3'b000,
    WE_GRN   = 3'b001,
    WE_YEL   = 3'b010,
    ALLRED_B = 3'b011,
    SN_GRN   = 3'b100,
    SN_YEL   = 3'b101,
    NIGHT    = 3'b110
  } state_t;

  typedef struct packed {
    logic we_red;
    logic we_yel;
    logic we_grn;
    logic sn_red;
    logic sn_yel;
    logic sn_grn;
  } lamps_t;

  localparam lamps_t LAMPS_ALLRED = 6'b100_100;
  localparam lamps_t LAMPS_WE_GRN = 6'b001_100;
  localparam lamps_t LAMPS_WE_YEL = 6'b010_100;
  localparam lamps_t LAMPS_SN_GRN = 6'b100_001;
  localparam lamps_t LAMPS_SN_YEL = 6'b100_010;

  // Lamp pattern for a state; in NIGHT both yellows follow the flash bit.
  function automatic lamps_t lamps_of(input state_t s, input logic flash);
    case (s)
      WE_GRN:  lamps_of = LAMPS_WE_GRN;
      WE_YEL:  lamps_of = LAMPS_WE_YEL;
      SN_GRN:  lamps_of = LAMPS_SN_GRN;
      SN_YEL:  lamps_of = LAMPS_SN_YEL;
      NIGHT:   lamps_of = {1'b0, flash, 1'b0, 1'b0, flash, 1'b0};
      default: lamps_of = LAMPS_ALLRED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down-counter holding the ticks remaining in the current phase.
// Load has priority over decrement; the count never wraps below zero.
module traffic_phase_timer #(
  parameter int             CNT_W   = 6,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on phase entry, otherwise step down while non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, asynchronously reset to the first phase's reload value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= RST_VAL;
    else      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-way (WE/SN) intersection controller with night flashing-yellow mode.
// Optional build macro TRAFFIC_SENSOR_EN adds car_we/car_sn inputs that hold
// a green phase while the cross direction has no waiting car.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             night,
`ifdef TRAFFIC_SENSOR_EN
  input  logic             car_we,
  input  logic             car_sn,
`endif
  output logic             we_red,
  output logic             we_yel,
  output logic             we_grn,
  output logic             sn_red,
  output logic             sn_yel,
  output logic             sn_grn,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase
);

  localparam logic [CNT_W-1:0] RL_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] RL_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] RL_ALLRED = CNT_W'(T_ALLRED - 1);

  state_t           state_q, state_d;
  logic             flash_q, flash_d;
  lamps_t           lamps_q, lamps_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;
  logic             done;

  // Reload value on entry to a state; NIGHT shows a constant zero.
  function automatic logic [CNT_W-1:0] reload_of(input state_t s);
    case (s)
      WE_GRN, SN_GRN: reload_of = RL_GREEN;
      WE_YEL, SN_YEL: reload_of = RL_YELLOW;
      NIGHT:          reload_of = '0;
      default:        reload_of = RL_ALLRED;
    endcase
  endfunction

  traffic_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RL_ALLRED)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec_en   (tick_en),
    .cnt      (remain),
    .zero     (zero)
  );

  assign done = tick_en && zero;

  // Phase sequencing: advance on completion, divert to NIGHT at the end of
  // yellow/all-red phases, and reload the timer whenever a phase is entered.
  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    load    = 1'b0;
    case (state_q)
      ALLRED_A: if (done) begin
        load    = 1'b1;
        state_d = night ? NIGHT : WE_GRN;
      end
      WE_GRN: if (done) begin
        load    = 1'b1;
        state_d = WE_YEL;
`ifdef TRAFFIC_SENSOR_EN
        if (!night && !car_sn) state_d = WE_GRN;
`endif
      end
      WE_YEL: if (done) begin
        load    = 1'b1;
        state_d = night ? NIGHT : ALLRED_B;
      end
      ALLRED_B: if (done) begin
        load    = 1'b1;
        state_d = night ? NIGHT : SN_GRN;
      end
      SN_GRN: if (done) begin
        load    = 1'b1;
        state_d = SN_YEL;
`ifdef TRAFFIC_SENSOR_EN
        if (!night && !car_we) state_d = SN_GRN;
`endif
      end
      SN_YEL: if (done) begin
        load    = 1'b1;
        state_d = night ? NIGHT : ALLRED_A;
      end
      NIGHT: if (tick_en) begin
        if (night) begin
          flash_d = ~flash_q;
        end else begin
          load    = 1'b1;
          state_d = ALLRED_A;
        end
      end
      default: begin
        load    = 1'b1;
        state_d = ALLRED_A;
      end
    endcase
    // Flash restarts dark on every NIGHT entry.
    if (state_d != NIGHT || state_q != NIGHT) flash_d = 1'b0;
    load_val = reload_of(state_d);
    lamps_d  = lamps_of(state_d, flash_d);
  end

  // State, flash bit and lamp outputs; lamps are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ALLRED_A;
      flash_q <= 1'b0;
      lamps_q <= LAMPS_ALLRED;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
      lamps_q <= lamps_d;
    end
  end

  assign we_red = lamps_q.we_red;
  assign we_yel = lamps_q.we_yel;
  assign we_grn = lamps_q.we_grn;
  assign sn_red = lamps_q.sn_red;
  assign sn_yel = lamps_q.sn_yel;
  assign sn_grn = lamps_q.sn_grn;
  assign phase  = state_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param (default parameters plus a
// single-tick-phase instance).
module tb_traffic_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       night;
  logic       car_we, car_sn;
  logic       we_red, we_yel, we_grn, sn_red, sn_yel, sn_grn;
  logic [5:0] remain;
  logic [2:0] phase;
  logic       b_we_red, b_we_yel, b_we_grn, b_sn_red, b_sn_yel, b_sn_grn;
  logic [5:0] b_remain;
  logic [2:0] b_phase;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] P_ARA = 3'b000, P_WEG = 3'b001, P_WEY = 3'b010,
                         P_ARB = 3'b011, P_SNG = 3'b100, P_SNY = 3'b101,
                         P_NGT = 3'b110;
  localparam logic [5:0] L_AR  = 6'b100100, L_WEG = 6'b001100,
                         L_WEY = 6'b010100, L_SNG = 6'b100001,
                         L_SNY = 6'b100010, L_NY1 = 6'b010010,
                         L_DARK = 6'b000000;

  wire [5:0] lamps = {we_red, we_yel, we_grn, sn_red, sn_yel, sn_grn};

  always #5 clk = ~clk;

  traffic_ctrl_param dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .night(night),
`ifdef TRAFFIC_SENSOR_EN
    .car_we(car_we), .car_sn(car_sn),
`endif
    .we_red(we_red), .we_yel(we_yel), .we_grn(we_grn),
    .sn_red(sn_red), .sn_yel(sn_yel), .sn_grn(sn_grn),
    .remain(remain), .phase(phase)
  );

  traffic_ctrl_param #(.CNT_W(6), .T_GREEN(1), .T_YELLOW(1), .T_ALLRED(1)) dut_b (
    .clk(clk), .rst(rst), .tick_en(tick_en), .night(night),
`ifdef TRAFFIC_SENSOR_EN
    .car_we(car_we), .car_sn(car_sn),
`endif
    .we_red(b_we_red), .we_yel(b_we_yel), .we_grn(b_we_grn),
    .sn_red(b_sn_red), .sn_yel(b_sn_yel), .sn_grn(b_sn_grn),
    .remain(b_remain), .phase(b_phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checkpoints in the first cycle, counted in ticks from reset release.
  int         cp_k   [8] = '{2, 31, 32, 36, 37, 39, 69, 74};
  logic [2:0] cp_ph  [8] = '{P_WEG, P_WEG, P_WEY, P_WEY, P_ARB, P_SNG, P_SNY, P_ARA};
  logic [5:0] cp_rem [8] = '{6'd29, 6'd0, 6'd4, 6'd0, 6'd1, 6'd29, 6'd4, 6'd1};
  logic [5:0] cp_lmp [8] = '{L_WEG, L_WEG, L_WEY, L_WEY, L_AR, L_SNG, L_SNY, L_AR};

  initial begin
    rst = 1'b0; tick_en = 1'b0; night = 1'b0; car_we = 1'b1; car_sn = 1'b1;
    @(posedge clk); #1;
    chk("reset_lamps",  lamps,  L_AR);
    chk("reset_remain", remain, 6'd1);
    chk("reset_phase",  phase,  P_ARA);
    chk("b_reset_remain", b_remain, 6'd0);

    // Full cycle with a tick every clock.
    rst = 1'b1; tick_en = 1'b1;
    for (int k = 1; k <= 74; k++) begin
      tick(1);
      chk("we_one_lamp", $countones({we_red, we_yel, we_grn}), 1);
      chk("sn_one_lamp", $countones({sn_red, sn_yel, sn_grn}), 1);
      if (k == 1) begin
        chk("b_k1_phase",  b_phase,  P_WEG);
        chk("b_k1_remain", b_remain, 6'd0);
      end
      if (k == 2) begin
        chk("b_k2_phase", b_phase, P_WEY);
        chk("b_k2_lamps", {b_we_red, b_we_yel, b_we_grn, b_sn_red, b_sn_yel, b_sn_grn}, L_WEY);
      end
      for (int i = 0; i < 8; i++) begin
        if (cp_k[i] == k) begin
          chk($sformatf("cyc%0d_phase", k),  phase,  cp_ph[i]);
          chk($sformatf("cyc%0d_remain", k), remain, cp_rem[i]);
          chk($sformatf("cyc%0d_lamps", k),  lamps,  cp_lmp[i]);
        end
      end
    end

    // Hold in SN_YEL with remain 3.
    tick(70);
    chk("hold_pre_phase",  phase,  P_SNY);
    chk("hold_pre_remain", remain, 6'd3);
    tick_en = 1'b0;
    tick(20);
    chk("hold_phase",  phase,  P_SNY);
    chk("hold_remain", remain, 6'd3);
    chk("hold_lamps",  lamps,  L_SNY);
    tick_en = 1'b1;

    // Night request mid-green: green and yellow still complete.
    tick(25);
    chk("ngt_green_phase",  phase,  P_WEG);
    chk("ngt_green_remain", remain, 6'd10);
    night = 1'b1;
    tick(11);
    chk("ngt_yel_phase",  phase,  P_WEY);
    chk("ngt_yel_remain", remain, 6'd4);
    tick(5);
    chk("ngt_entry_phase",  phase,  P_NGT);
    chk("ngt_entry_remain", remain, 6'd0);
    chk("ngt_entry_lamps",  lamps,  L_DARK);
    tick(1);
    chk("ngt_flash1", lamps, L_NY1);
    tick(1);
    chk("ngt_flash0", lamps, L_DARK);
    tick(1);
    chk("ngt_flash1b", lamps, L_NY1);
    chk("ngt_remain", remain, 6'd0);
    night = 1'b0;
    tick(1);
    chk("ngt_exit_phase",  phase,  P_ARA);
    chk("ngt_exit_remain", remain, 6'd1);
    chk("ngt_exit_lamps",  lamps,  L_AR);

    // Asynchronous reset during SN_GRN.
    tick(45);
    chk("rst_pre_phase",  phase,  P_SNG);
    chk("rst_pre_remain", remain, 6'd23);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_phase",  phase,  P_ARA);
    chk("arst_lamps",  lamps,  L_AR);
    chk("arst_remain", remain, 6'd1);
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("post_rst_phase",  phase,  P_WEG);
    chk("post_rst_remain", remain, 6'd29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
Parametrised two-way intersection controller for the WE and SN directions.
- Sequences a full six-phase cycle: WE green, WE yellow, all-red, SN green, SN yellow, all-red.
- Phase durations are parameters, counted in ticks of an external enable pulse.
- Exports a per-phase remaining-time countdown for the display block.
- Adds a night flashing-yellow mode.
- Sits between the 1 Hz tick generator and the lamp and seven-segment drivers.

Parameters:
- CNT_W, 6: width of the countdown and timer.
- T_GREEN, 30: green duration in ticks; range 1..2^CNT_W-1.
- T_YELLOW, 5: yellow duration in ticks; range 1..2^CNT_W-1.
- T_ALLRED, 2: all-red clearance in ticks; range 1..2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tick_en  in  1  one-clk-wide timing pulse; all timing advances only when it is 1
- night  in  1  night-mode request, level, synchronous to clk
- we_red, we_yel, we_grn  out  1 each  WE lamps
- sn_red, sn_yel, sn_grn  out  1 each  SN lamps
- remain  out  CNT_W  ticks left in current phase, minus 1
- phase  out  3  current state encoding, from the package

Behaviour:
States: ALLRED_A, WE_GRN, WE_YEL, ALLRED_B, SN_GRN, SN_YEL, NIGHT.

Reset (rst=0, asynchronous):
- State = ALLRED_A and remain = T_ALLRED-1.
- we_red = sn_red = 1; all other lamps 0.

Outputs:
- Lamps and phase are a Moore decode of the state register only.
- remain is registered.
- No output depends on tick_en or night combinationally.

Timing:
- On phase entry, remain loads T_x-1.
- Each clk with tick_en=1 and remain!=0: remain decrements by 1.
- tick_en=1 and remain==0 completes the phase. The next state is entered on that same clk edge, with remain reloaded.
- tick_en=0: state and remain hold.

Phase transitions:
- ALLRED_A -> WE_GRN -> WE_YEL -> ALLRED_B -> SN_GRN -> SN_YEL -> ALLRED_A.
- One full cycle = 2*(T_GREEN+T_YELLOW+T_ALLRED) ticks.

Lamp map:
- ALLRED_x: both red.
- WE_GRN: we_grn + sn_red.
- WE_YEL: we_yel + sn_red.
- SN_GRN: sn_grn + we_red.
- SN_YEL: sn_yel + we_red.
- Exactly one lamp per direction is lit in every normal phase.

Night mode:
- night is sampled only at completion of a YEL or ALLRED phase.
- If it is 1 there, the next state is NIGHT instead of the normal successor.
- A green phase always runs to completion and then passes through its yellow.
- In NIGHT:
  - reds and greens = 0; remain = 0.
  - A flash bit, cleared on NIGHT entry, toggles on each tick_en.
  - we_yel = sn_yel = flash bit.
- Exit: tick_en=1 with night=0 goes to ALLRED_A with remain = T_ALLRED-1.

Boundary conditions:
- A T_x of 1 gives a single-tick phase, with remain = 0 on entry.
- night changing mid-phase has no effect until the phase completes.
- Reset mid-operation returns to ALLRED_A immediately.
- An unused state encoding recovers to ALLRED_A on the next clk.

Optional Feature:
Macro TRAFFIC_SENSOR_EN.

Defined:
- Adds inputs car_we and car_sn (1 bit each, level).
- At completion of WE_GRN with car_sn=0, WE_GRN is re-entered with remain = T_GREEN-1 rather than advancing. SN_GRN with car_we=0 behaves symmetrically.
- Extension repeats indefinitely while the cross direction is empty.
- night=1 at green completion overrides extension: the block proceeds to yellow.

Undefined:
- Ports are absent and the cycle is fixed.

Decomposition:
Package traffic_pkg holds:
- The phase state encoding, with NIGHT = 3'b110.
- The lamp-vector constants per state.

Sub-module traffic_phase_timer: a loadable CNT_W down-counter with these ports:
- load, load_val
- dec_en (tied to tick_en)
- zero flag

The FSM, lamp decode and night flash bit stay in the top module.

Test Plan:
Use default parameters with tick_en=1 every clk unless stated.
- Reset then release -> we_red = sn_red = 1 and remain = 1. After 2 ticks: WE_GRN, remain = 29, we_grn = 1, sn_red = 1.
- Run 74 ticks from ALLRED_A -> pass WE_GRN(30), WE_YEL(5), ALLRED_B(2), SN_GRN(30), SN_YEL(5) in order and return to ALLRED_A. Exactly one lamp per direction is lit each cycle.
- Hold tick_en=0 for 20 clk during SN_YEL with remain = 3 -> state and remain are unchanged.
- Assert night at WE_GRN remain = 10 -> WE_YEL still runs 5 ticks, then NIGHT. Yellows toggle 1,0,1 on successive ticks. Deassert night -> ALLRED_A with remain = 1.
- With TRAFFIC_SENSOR_EN and car_sn=0 -> WE_GRN repeats for 90 ticks. Raise car_sn -> WE_YEL at the next green completion.
- Assert rst during SN_GRN -> ALLRED_A and both reds on asynchronously, before the next clk edge.
